capture_seq: RTL and testbench

CAPTURE_SEQ -- requirements
Module: capture_seq

---
 rtl/capture_pkg.sv | 28 ++
 rtl/pix_line_counter.sv | 56 +++++
 rtl/capture_seq.sv | 185 ++++++++++++++++++
 tb/tb_capture_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// ---------------------------------------------------------------------------
// capture_pkg
// Shared definitions for the image capture sequencer: FSM state encodings,
// default values of the top-level parameters and the counter widths.
// ---------------------------------------------------------------------------
package capture_pkg;

    // Encodings are observable on the debug state port, so they are fixed.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_CFG   = 3'd1,
        ST_REQ        = 3'd2,
        ST_WAIT_FRAME = 3'd3,
        ST_CAPTURE    = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;

    localparam int unsigned DEF_PIXELS_PER_LINE  = 648;
    localparam int unsigned DEF_LINES_PER_FRAME  = 488;
    localparam int unsigned DEF_FRAME_REQ_CYCLES = 4;
    localparam logic [23:0] DEF_TIMEOUT_CYCLES   = 24'd10_000_000;

    localparam int unsigned PIX_W  = 10;
    localparam int unsigned LINE_W = 10;
    localparam int unsigned TO_W   = 24;

endpackage

// File: rtl/pix_line_counter.sv
// ---------------------------------------------------------------------------
// pix_line_counter
// Pixel-within-line and line-within-frame counters for the capture sequencer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   inc         : one accepted pixel beat this cycle
//   clr         : synchronous clear of both counters (wins over inc)
//   line_count  : number of completed lines in the current frame
//   frame_last  : the current pixel is the last pixel of the last line, so an
//                 accepted beat now completes the frame
// ---------------------------------------------------------------------------
module pix_line_counter
    import capture_pkg::*;
#(
    parameter int unsigned PIXELS_PER_LINE = DEF_PIXELS_PER_LINE,
    parameter int unsigned LINES_PER_FRAME = DEF_LINES_PER_FRAME
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [LINE_W-1:0] line_count,
    output logic              frame_last
);

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIXELS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);

    logic [PIX_W-1:0]  r_pix_cnt;
    logic [LINE_W-1:0] r_line_cnt;
    logic              w_pix_wrap;

    assign w_pix_wrap = (r_pix_cnt == PIX_LAST);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of the others, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (clr) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (inc) begin
            if (w_pix_wrap) begin
                r_pix_cnt  <= '0;
                r_line_cnt <= r_line_cnt + LINE_W'(1);
            end else begin
                r_pix_cnt  <= r_pix_cnt + PIX_W'(1);
            end
        end
    end

    assign frame_last = w_pix_wrap && (r_line_cnt == LINE_LAST);
    assign line_count = r_line_cnt;

endmodule

// File: rtl/capture_seq.sv
// ---------------------------------------------------------------------------
// capture_seq
// Sequencer for one sensor frame capture: waits for sensor configuration,
// pulses a frame request, forwards pixel beats to the image FIFO, and flags
// overflow or beat timeouts.
//   clk, rst_n              : clock, asynchronous active-low reset
//   start                   : capture trigger (rising edge acts, IDLE only)
//   abort                   : forces IDLE, highest priority
//   cfg_done                : sensor configuration complete
//   line_valid, data_valid  : sensor beat qualifiers (beat = both high)
//   fifo_full               : image FIFO cannot take a beat
//   frame_req               : frame request pulse to the sensor
//   fifo_wr_en              : image FIFO write enable (combinational)
//   busy, done              : not-IDLE flag, one-cycle frame-complete strobe
//   err_overflow            : sticky, beat arrived while FIFO full
//   err_timeout             : sticky, no beat for TIMEOUT_CYCLES cycles
//   line_count              : completed lines of the current frame
//   state                   : raw state encoding for debug probing
// ---------------------------------------------------------------------------
module capture_seq
    import capture_pkg::*;
#(
    parameter int unsigned     PIXELS_PER_LINE  = DEF_PIXELS_PER_LINE,
    parameter int unsigned     LINES_PER_FRAME  = DEF_LINES_PER_FRAME,
    parameter int unsigned     FRAME_REQ_CYCLES = DEF_FRAME_REQ_CYCLES,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_done,
    input  logic              line_valid,
    input  logic              data_valid,
    input  logic              fifo_full,
    output logic              frame_req,
    output logic              fifo_wr_en,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_timeout,
    output logic [LINE_W-1:0] line_count,
    output logic [2:0]        state
);

    localparam int unsigned    REQ_W    = (FRAME_REQ_CYCLES > 1) ? $clog2(FRAME_REQ_CYCLES) : 1;
    localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(FRAME_REQ_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_dec;
    state_t            w_next_state;
    logic              r_start_q;
    logic              r_frame_req;
    logic [REQ_W-1:0]  r_req_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_err_overflow;
    logic              r_err_timeout;

    logic              w_start_edge;
    logic              w_beat;
    logic              w_to_expire;
    logic              w_frame_last;
    logic              w_accept;
    logic              w_clr_all;
    logic              w_set_ovf;
    logic              w_set_to;
    logic              w_to_clr;
    logic              w_to_inc;

    assign w_start_edge = start & ~r_start_q;
    assign w_beat       = line_valid & data_valid;
    assign w_to_expire  = (r_to_cnt == TIMEOUT_CYCLES - TO_W'(1));

    // The unused encoding 7 behaves exactly like IDLE.
    assign w_state_dec = (r_state == ST_ERROR + 3'd1) ? ST_IDLE : r_state;

    pix_line_counter #(
        .PIXELS_PER_LINE (PIXELS_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME)
    ) u_pix_line_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (w_accept),
        .clr        (w_clr_all),
        .line_count (line_count),
        .frame_last (w_frame_last)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = w_state_dec;
        w_clr_all    = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_to     = 1'b0;
        w_accept     = 1'b0;
        w_to_clr     = 1'b0;
        w_to_inc     = 1'b0;

        case (w_state_dec)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_next_state = ST_WAIT_CFG;
                    w_clr_all    = 1'b1;
                end
            end
            ST_WAIT_CFG: begin
                if (cfg_done) w_next_state = ST_REQ;
            end
            ST_REQ: begin
                if (r_req_cnt == REQ_LAST) w_next_state = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME, ST_CAPTURE: begin
                // A beat outranks a timeout expiring in the same cycle.
                if (w_beat) begin
                    w_to_clr = 1'b1;
                    if (fifo_full) begin
                        w_set_ovf    = 1'b1;
                        w_next_state = ST_ERROR;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = w_frame_last ? ST_DONE : ST_CAPTURE;
                    end
                end else begin
                    w_to_inc = 1'b1;
                    if (w_to_expire) begin
                        w_set_to     = 1'b1;
                        w_next_state = ST_ERROR;
                    end
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            ST_ERROR: w_next_state = ST_ERROR;
            default:  w_next_state = ST_IDLE;
        endcase

        // Abort returns to IDLE and freezes counters and error flags.
        if (abort) begin
            w_next_state = ST_IDLE;
            w_clr_all    = 1'b0;
            w_set_ovf    = 1'b0;
            w_set_to     = 1'b0;
            w_accept     = 1'b0;
            w_to_clr     = 1'b0;
            w_to_inc     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_start_q      <= 1'b1;  // start held high through reset is not an edge
            r_frame_req    <= 1'b0;
            r_req_cnt      <= '0;
            r_to_cnt       <= '0;
            r_err_overflow <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_start_q   <= start;
            // Registered from the current state, so the request trails REQ
            // entry by one cycle and lasts exactly as long as REQ.
            r_frame_req <= (w_state_dec == ST_REQ) & ~abort;
            r_req_cnt   <= (w_state_dec == ST_REQ) ? r_req_cnt + REQ_W'(1) : '0;

            if (w_clr_all || w_to_clr) r_to_cnt <= '0;
            else if (w_to_inc)         r_to_cnt <= r_to_cnt + TO_W'(1);

            if (w_clr_all)      r_err_overflow <= 1'b0;
            else if (w_set_ovf) r_err_overflow <= 1'b1;

            if (w_clr_all)     r_err_timeout <= 1'b0;
            else if (w_set_to) r_err_timeout <= 1'b1;
        end
    end

    assign frame_req    = r_frame_req & ~abort;
    assign fifo_wr_en   = w_accept;
    assign busy         = (w_state_dec != ST_IDLE);
    assign done         = (w_state_dec == ST_DONE);
    assign err_overflow = r_err_overflow;
    assign err_timeout  = r_err_timeout;
    assign state        = r_state;

endmodule

// File: tb/tb_capture_seq.sv
// ---------------------------------------------------------------------------
// tb_capture_seq
// Directed bench for capture_seq with 4 pixels/line, 2 lines/frame, a
// 4-cycle frame request and a 50-cycle beat timeout. Inputs change on the
// falling edge; outputs are compared 1 time unit later.
// ---------------------------------------------------------------------------
module tb_capture_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       cfg_done;
    logic       line_valid;
    logic       data_valid;
    logic       fifo_full;
    logic       frame_req;
    logic       fifo_wr_en;
    logic       busy;
    logic       done;
    logic       err_overflow;
    logic       err_timeout;
    logic [9:0] line_count;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_wr    = 0;
    int exp_st [1:7];

    capture_seq #(
        .PIXELS_PER_LINE  (4),
        .LINES_PER_FRAME  (2),
        .FRAME_REQ_CYCLES (4),
        .TIMEOUT_CYCLES   (24'd50)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_done     (cfg_done),
        .line_valid   (line_valid),
        .data_valid   (data_valid),
        .fifo_full    (fifo_full),
        .frame_req    (frame_req),
        .fifo_wr_en   (fifo_wr_en),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout),
        .line_count   (line_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) n_done++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"},     state,        0);
        check({tag, "_frame_req"}, frame_req,    0);
        check({tag, "_wr_en"},     fifo_wr_en,   0);
        check({tag, "_busy"},      busy,         0);
        check({tag, "_done"},      done,         0);
        check({tag, "_ovf"},       err_overflow, 0);
        check({tag, "_to"},        err_timeout,  0);
        check({tag, "_lines"},     line_count,   0);
    endtask

    // Start edge at the next falling edge; returns 1 unit after the sixth
    // falling edge later, the first cycle of WAIT_FRAME (cfg_done must be 1).
    task automatic launch(input bit hold_start);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("launch_state", state, 3);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_done = 1'b1;
        line_valid = 1'b0; data_valid = 1'b0; fifo_full = 1'b0;
        exp_st = '{1, 2, 2, 2, 2, 3, 3};

        #3;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame: request timing, 8 writes, one done, two lines.
        @(negedge clk);
        start = 1'b1;
        #1;
        check("s1_pre_state", state, 0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) start = 1'b0;
            check("s1_state", state, exp_st[k]);
            check("s1_frame_req", frame_req, (k >= 3 && k <= 6) ? 1 : 0);
        end
        for (int b = 0; b < 8; b++) begin
            line_valid = 1'b1; data_valid = 1'b1;
            #1;
            check("s1_beat_wr", fifo_wr_en, 1);
            if (fifo_wr_en === 1'b1) n_wr++;
            @(negedge clk);
        end
        line_valid = 1'b0; data_valid = 1'b0;
        #1;
        check("s1_done", done, 1);
        check("s1_done_state", state, 5);
        check("s1_done_wr", fifo_wr_en, 0);
        check("s1_lines", line_count, 2);
        @(negedge clk);
        #1;
        check("s1_idle_state", state, 0);
        check("s1_idle_busy", busy, 0);
        check("s1_lines_hold", line_count, 2);
        check("s1_wr_total", n_wr, 8);
        check("s1_done_pulses", n_done, 1);

        // Configuration not complete: hold in WAIT_CFG with no request.
        cfg_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) start = 1'b0;
            check("s2_wait_state", state, 1);
            check("s2_wait_req", frame_req, 0);
        end
        cfg_done = 1'b1;
        @(negedge clk);
        #1;
        check("s2_req_state", state, 2);
        check("s2_req_low", frame_req, 0);
        @(negedge clk);
        #1;
        check("s2_req_high", frame_req, 1);
        abort = 1'b1;
        #1;
        check("s2_abort_req", frame_req, 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("s2_abort_state", state, 0);
        check("s2_abort_req_after", frame_req, 0);

        // FIFO full on the third beat.
        launch(0);
        line_valid = 1'b1; data_valid = 1'b1;
        #1;
        check("s3_beat1_wr", fifo_wr_en, 1);
        @(negedge clk);
        #1;
        check("s3_beat2_wr", fifo_wr_en, 1);
        @(negedge clk);
        fifo_full = 1'b1;
        #1;
        check("s3_beat3_wr", fifo_wr_en, 0);
        @(negedge clk);
        fifo_full = 1'b0;
        #1;
        check("s3_err_state", state, 6);
        check("s3_err_ovf", err_overflow, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("s3_hold_state", state, 6);
            check("s3_hold_wr", fifo_wr_en, 0);
        end
        abort = 1'b1;
        line_valid = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("s3_abort_state", state, 0);
        check("s3_abort_ovf", err_overflow, 1);

        // No beats: timeout after 50 cycles of WAIT_FRAME.
        launch(0);
        check("s4_ovf_cleared", err_overflow, 0);
        repeat (49) @(negedge clk);
        #1;
        check("s4_cycle50_state", state, 3);
        check("s4_cycle50_to", err_timeout, 0);
        @(negedge clk);
        #1;
        check("s4_to_flag", err_timeout, 1);
        check("s4_to_state", state, 6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("s4_abort_state", state, 0);
        check("s4_abort_to", err_timeout, 1);

        // Beat on the expiry cycle wins.
        launch(0);
        check("s4b_to_cleared", err_timeout, 0);
        repeat (49) @(negedge clk);
        line_valid = 1'b1; data_valid = 1'b1;
        #1;
        check("s4b_expiry_wr", fifo_wr_en, 1);
        @(negedge clk);
        line_valid = 1'b0; data_valid = 1'b0;
        #1;
        check("s4b_state", state, 4);
        check("s4b_to", err_timeout, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Abort mid-capture.
        launch(0);
        line_valid = 1'b1; data_valid = 1'b1;
        #1;
        check("s5_beat_wr", fifo_wr_en, 1);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("s5_abort_wr", fifo_wr_en, 0);
        @(negedge clk);
        abort = 1'b0;
        line_valid = 1'b0; data_valid = 1'b0;
        #1;
        check("s5_abort_state", state, 0);

        // Asynchronous reset mid-frame with start held high.
        launch(1);
        check("s6_req_high", frame_req, 1);
        line_valid = 1'b1; data_valid = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("s6_async_rst");
        line_valid = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("s6_no_req", frame_req, 0);
            check("s6_no_edge_state", state, 0);
        end
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
